// File: rtl/rec_hold_ctrl_pkg.sv
// Shared definitions for the record-start prompt screen: screen/state encoding
// and OLED geometry used by both the control path and the pixel renderers.
package rec_hold_ctrl_pkg;

  typedef enum logic [1:0] {
    PROMPT    = 2'd0,
    HOLDING   = 2'd1,
    RECORDING = 2'd2
  } screen_t;

  localparam int unsigned OLED_WIDTH   = 96;
  localparam logic [6:0]  PROGRESS_MAX = 7'(OLED_WIDTH - 1);

  // Counter width for a count that runs 0..limit-1 (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability-count debouncer and
// one-cycle press/release events aligned with the debounced level change.
module btn_debounce
  import rec_hold_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 62500
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_rel
);

  localparam int unsigned    CW       = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;
  logic          r_rel;
  logic          w_differ;

  assign w_differ = r_sync[1] ^ r_level;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_press <= 1'b0;
      r_rel   <= 1'b0;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
        r_press <= ~r_level;
        r_rel   <= r_level;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;
  assign o_rel   = r_rel;

endmodule

// File: rtl/rec_hold_ctrl.sv
// Record-start prompt control: press-and-hold arming, progress bar width,
// recording window with auto-timeout, and record start/stop pulses.
module rec_hold_ctrl
  import rec_hold_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = 62500,
  parameter int unsigned HOLD_CYCLES    = 6250000,
  parameter int unsigned MAX_REC_CYCLES = 31250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       btn_c,
  output logic [1:0] screen_sel,
  output logic [6:0] hold_progress,
  output logic       rec_active,
  output logic       rec_start,
  output logic       rec_stop
);

  localparam int unsigned STEP = HOLD_CYCLES / OLED_WIDTH;
  localparam int unsigned HW   = cnt_width(HOLD_CYCLES);
  localparam int unsigned SW   = cnt_width(STEP);
  localparam int unsigned RW   = cnt_width(MAX_REC_CYCLES);

  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEP - 1);
  localparam logic [RW-1:0] REC_LAST   = RW'(MAX_REC_CYCLES - 1);
  localparam logic [SW-1:0] STEP_ENTRY = SW'((STEP > 1) ? 1 : 0);
  localparam logic [6:0]    PROG_ENTRY = 7'((STEP == 1) ? 1 : 0);

  logic w_level;
  logic w_press;
  logic w_rel;

  screen_t       r_state;
  logic [HW-1:0] r_hold_cnt;
  logic [SW-1:0] r_step_cnt;
  logic [RW-1:0] r_rec_cnt;
  logic [6:0]    r_progress;
  logic          r_wait_rel;
  logic          r_rec_active;
  logic          r_rec_start;
  logic          r_rec_stop;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_debounce (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_btn   (btn_c),
    .o_level (w_level),
    .o_press (w_press),
    .o_rel   (w_rel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= PROMPT;
      r_hold_cnt   <= '0;
      r_step_cnt   <= '0;
      r_rec_cnt    <= '0;
      r_progress   <= '0;
      r_wait_rel   <= 1'b0;
      r_rec_active <= 1'b0;
      r_rec_start  <= 1'b0;
      r_rec_stop   <= 1'b0;
    end else begin
      r_rec_start <= 1'b0;
      r_rec_stop  <= 1'b0;
      unique case (r_state)
        PROMPT: begin
          r_hold_cnt <= '0;
          r_step_cnt <= '0;
          r_progress <= '0;
          // The press_evt cycle is the first held cycle, so HOLDING starts at count 1.
          if (enable && w_press) begin
            r_state    <= HOLDING;
            r_hold_cnt <= HW'(1);
            r_step_cnt <= STEP_ENTRY;
            r_progress <= PROG_ENTRY;
          end
        end
        HOLDING: begin
          if (!enable || !w_level) begin
            r_state    <= PROMPT;
            r_hold_cnt <= '0;
            r_step_cnt <= '0;
            r_progress <= '0;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_state      <= RECORDING;
            r_rec_start  <= 1'b1;
            r_rec_active <= 1'b1;
            r_wait_rel   <= 1'b1;
            r_progress   <= PROGRESS_MAX;
            r_hold_cnt   <= '0;
            r_step_cnt   <= '0;
            r_rec_cnt    <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
            if (r_step_cnt == STEP_LAST) begin
              r_step_cnt <= '0;
              if (r_progress != PROGRESS_MAX) begin
                r_progress <= r_progress + 7'd1;
              end
            end else begin
              r_step_cnt <= r_step_cnt + SW'(1);
            end
          end
        end
        RECORDING: begin
          // All stop causes merge into one exit, so coincident causes give a single pulse.
          if (!enable || (r_rec_cnt == REC_LAST) || (w_press && !r_wait_rel)) begin
            r_state      <= PROMPT;
            r_rec_stop   <= 1'b1;
            r_rec_active <= 1'b0;
            r_rec_cnt    <= '0;
            r_wait_rel   <= 1'b0;
            r_progress   <= '0;
          end else begin
            r_rec_cnt <= r_rec_cnt + RW'(1);
            if (w_rel) begin
              r_wait_rel <= 1'b0;
            end
          end
        end
        default: r_state <= PROMPT;
      endcase
    end
  end

  assign screen_sel    = r_state;
  assign hold_progress = r_progress;
  assign rec_active    = r_rec_active;
  assign rec_start     = r_rec_start;
  assign rec_stop      = r_rec_stop;

endmodule

// File: tb/tb_rec_hold_ctrl.sv
// Randomised bench for rec_hold_ctrl against a timestamp-based behavioural model
// of the debounce, hold-to-record and recording-window rules.
module tb_rec_hold_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 96;
  localparam int MAXR = 200;
  localparam int STEP = HOLD / 96;
  localparam int HL   = DEB + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable;
  logic       btn_c;
  logic [1:0] screen_sel;
  logic [6:0] hold_progress;
  logic       rec_active;
  logic       rec_start;
  logic       rec_stop;

  int n_checks = 0;
  int n_errors = 0;

  rec_hold_ctrl #(
    .DEB_CYCLES     (DEB),
    .HOLD_CYCLES    (HOLD),
    .MAX_REC_CYCLES (MAXR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .btn_c         (btn_c),
    .screen_sel    (screen_sel),
    .hold_progress (hold_progress),
    .rec_active    (rec_active),
    .rec_start     (rec_start),
    .rec_stop      (rec_stop)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit m_hist [HL];
  bit m_level, m_press, m_rel, m_wait, m_start, m_stop;
  int m_mode, m_cyc, m_p, m_rs;

  task automatic model_reset();
    for (int i = 0; i < HL; i++) m_hist[i] = 1'b0;
    m_level = 0; m_press = 0; m_rel = 0; m_wait = 0;
    m_start = 0; m_stop = 0; m_mode = 0; m_p = 0; m_rs = 0;
  endtask

  task automatic model_step();
    bit old_press, old_rel, old_lvl, all_diff;
    m_cyc++;
    old_press = m_press; old_rel = m_rel; old_lvl = m_level;
    for (int i = HL - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = btn_c;
    // Level flips once the last DEB synchronised samples all disagree with it.
    all_diff = 1'b1;
    for (int i = 2; i < HL; i++) if (m_hist[i] == m_level) all_diff = 1'b0;
    m_press = all_diff && !m_level;
    m_rel   = all_diff && m_level;
    if (all_diff) m_level = !m_level;
    m_start = 0; m_stop = 0;
    if (m_mode == 0) begin
      if (old_press && enable) begin m_mode = 1; m_p = m_cyc - 1; end
    end else if (m_mode == 1) begin
      if (!enable || !old_lvl) m_mode = 0;
      else if (m_cyc - m_p == HOLD) begin m_mode = 2; m_rs = m_cyc; m_start = 1; m_wait = 1; end
    end else begin
      if (!enable || (m_cyc - m_rs == MAXR) || (old_press && !m_wait)) begin
        m_mode = 0; m_stop = 1; m_wait = 0;
      end else if (old_rel) m_wait = 0;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  function automatic int exp_progress();
    int v;
    if (m_mode == 1) begin
      v = (m_cyc - m_p) / STEP;
      return (v > 95) ? 95 : v;
    end
    return (m_mode == 2) ? 95 : 0;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  int tb_cyc = 0, n_start = 0, n_stop = 0, t_start = 0, t_stop = 0;
  int dut_peak = 0, exp_peak = 0;

  task automatic compare_outputs();
    tb_cyc++;
    check("screen_sel", 32'(screen_sel), 32'(m_mode));
    check("hold_progress", 32'(hold_progress), 32'(exp_progress()));
    check("rec_active", 32'(rec_active), 32'(m_mode == 2));
    check("rec_start", 32'(rec_start), 32'(m_start));
    check("rec_stop", 32'(rec_stop), 32'(m_stop));
    if (rec_start) begin n_start++; t_start = tb_cyc; end
    if (rec_stop)  begin n_stop++;  t_stop  = tb_cyc; end
    if (int'(hold_progress) > dut_peak) dut_peak = int'(hold_progress);
    if (exp_progress() > exp_peak) exp_peak = exp_progress();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      compare_outputs();
    end
  endtask

  task automatic wait_sel(input logic [1:0] want, input int limit, input string tag);
    int k;
    k = 0;
    while (screen_sel !== want && k < limit) begin
      run(1);
      k++;
    end
    check(tag, 32'(screen_sel), 32'(want));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    btn_c  = 1'b0;
    enable = 1'b1;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sel", 32'(screen_sel), 0);
    check("rst_prog", 32'(hold_progress), 0);
    check("rst_active", 32'(rec_active), 0);
    check("rst_start", 32'(rec_start), 0);
    check("rst_stop", 32'(rec_stop), 0);
    reset = 1'b0;

    // Glitch shorter than the debounce window
    btn_c = 1'b1; run(3);
    btn_c = 1'b0; run(15);
    check("glitch_sel", 32'(screen_sel), 0);

    // Short hold then release
    n_start = 0; dut_peak = 0; exp_peak = 0;
    btn_c = 1'b1; run(5 + $urandom_range(40, 60));
    btn_c = 1'b0; run(20);
    check("short_no_start", n_start, 0);
    check("short_sel", 32'(screen_sel), 0);
    check("short_peak", dut_peak, exp_peak);

    // Full hold into recording, keep holding
    n_start = 0; n_stop = 0;
    btn_c = 1'b1;
    wait_sel(2'd2, 150, "full_enter");
    check("full_prog", 32'(hold_progress), 95);
    check("full_active", 32'(rec_active), 1);
    run(30);
    check("full_start_once", n_start, 1);
    check("full_no_stop", n_stop, 0);
    check("full_still_rec", 32'(screen_sel), 2);

    // Manual stop: release then press again
    btn_c = 1'b0; run(15);
    n_stop = 0;
    btn_c = 1'b1; run(15);
    check("manual_stop_once", n_stop, 1);
    check("manual_sel", 32'(screen_sel), 0);
    check("manual_active", 32'(rec_active), 0);
    btn_c = 1'b0; run(20);

    // Timeout with button held throughout
    n_start = 0; n_stop = 0;
    btn_c = 1'b1;
    wait_sel(2'd2, 150, "timeout_enter");
    run(260);
    check("timeout_start_once", n_start, 1);
    check("timeout_stop_once", n_stop, 1);
    check("timeout_gap", t_stop - t_start, MAXR);
    check("timeout_prompt_held", 32'(screen_sel), 0);
    btn_c = 1'b0; run(15);
    btn_c = 1'b1; run(12);
    check("rearm_holding", 32'(screen_sel), 1);
    btn_c = 1'b0; run(20);

    // Async reset between edges mid-recording
    btn_c = 1'b1;
    wait_sel(2'd2, 150, "areset_enter");
    run(5);
    n_stop = 0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset_sel", 32'(screen_sel), 0);
    check("areset_prog", 32'(hold_progress), 0);
    check("areset_active", 32'(rec_active), 0);
    check("areset_start", 32'(rec_start), 0);
    check("areset_stop", 32'(rec_stop), 0);
    #1 reset = 1'b0;
    btn_c = 1'b0; run(20);
    check("areset_no_stop", n_stop, 0);

    // Enable low while recording
    btn_c = 1'b1;
    wait_sel(2'd2, 150, "en_enter");
    btn_c = 1'b0; run(10);
    n_stop = 0;
    enable = 1'b0; run(6);
    check("en_stop_once", n_stop, 1);
    check("en_sel", 32'(screen_sel), 0);
    enable = 1'b1; run(5);

    // Enable low while holding, held button must not re-arm
    btn_c = 1'b1;
    wait_sel(2'd1, 30, "en_hold_enter");
    run(10);
    n_stop = 0;
    enable = 1'b0; run(3);
    check("en_hold_sel", 32'(screen_sel), 0);
    enable = 1'b1; run(20);
    check("en_hold_no_rearm", 32'(screen_sel), 0);
    check("en_hold_no_stop", n_stop, 0);
    btn_c = 1'b0; run(20);

    // Random button/enable patterns
    for (int i = 0; i < 60; i++) begin
      btn_c  = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 9) != 0);
      run($urandom_range(1, 130));
    end
    enable = 1'b1; btn_c = 1'b0; run(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
